bus_sequencer: RTL



---
 rtl/bus_pkg.sv | 71 +++++++
 rtl/op_decoder.sv | 48 ++++
 rtl/bus_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the Mini SRC bus sequencer:
// bus-mux selects, opcodes, FSM states and instruction classes.
package bus_pkg;

  localparam logic [4:0] SEL_R0  = 5'd0;
  localparam logic [4:0] SEL_HI  = 5'd16;
  localparam logic [4:0] SEL_LO  = 5'd17;
  localparam logic [4:0] SEL_ZHI = 5'd18;
  localparam logic [4:0] SEL_ZLO = 5'd19;
  localparam logic [4:0] SEL_PC  = 5'd20;
  localparam logic [4:0] SEL_MDR = 5'd21;
  localparam logic [4:0] SEL_IN  = 5'd22;
  localparam logic [4:0] SEL_C   = 5'd23;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_RTYPE,
    CL_IMM,
    CL_MULDIV,
    CL_LD,
    CL_ST,
    CL_MFHI,
    CL_MFLO,
    CL_IN,
    CL_OUT,
    CL_HALT
  } class_e;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/op_decoder.sv
// Opcode to instruction-class decoder (pure combinational).
// Ports: op_i opcode in; cls_o class, imm_o C-operand, muldiv_o HI/LO.
// INPORT_EN: when defined, in/out opcodes decode to CL_IN/CL_OUT.
module op_decoder
  import bus_pkg::*;
(
  input  logic [4:0] op_i,
  output class_e     cls_o,
  output logic       imm_o,
  output logic       muldiv_o
);

  always_comb begin
    cls_o    = CL_NOP;
    imm_o    = 1'b0;
    muldiv_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_NEG, OP_NOT: cls_o = CL_RTYPE;
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin
        cls_o = CL_IMM;
        imm_o = 1'b1;
      end
      OP_LD: begin
        cls_o = CL_LD;
        imm_o = 1'b1;
      end
      OP_ST: begin
        cls_o = CL_ST;
        imm_o = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        cls_o    = CL_MULDIV;
        muldiv_o = 1'b1;
      end
      OP_MFHI: cls_o = CL_MFHI;
      OP_MFLO: cls_o = CL_MFLO;
      OP_HALT: cls_o = CL_HALT;
`ifdef INPORT_EN
      OP_IN:   cls_o = CL_IN;
      OP_OUT:  cls_o = CL_OUT;
`endif
      default: cls_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the Mini SRC single bus.
// Ports: clock/clear/run control; ir, mem_ready in; bus_sel, reg_in,
// special-register loads, alu_op, memory strobes and status out.
// INPORT_EN: when defined, enables in/out opcodes (bus_sel 22, outport_in).
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter logic [31:0] PC_RESET     = 32'd0
)(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [4:0]  bus_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mdr_src_mem,
  output logic        pc_load_reset,
  output logic        busy,
  output logic        halted,
  output logic        mem_fault,
  output logic        outport_in,
  output logic [31:0] pc_reset_value
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          fault_q, fault_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  class_e     cls;
  logic       imm;
  logic       muldiv;
  logic       strobe;
  logic       timeout;
  state_e     done_st;
  logic       unused_ir;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  // Low C bits feed the ALU directly via the SEL_C path.
  assign unused_ir = ^{ir[14:0], muldiv};

  assign pc_reset_value = PC_RESET;

  op_decoder u_dec (
    .op_i     (op),
    .cls_o    (cls),
    .imm_o    (imm),
    .muldiv_o (muldiv)
  );

  // Memory strobe is held in these states until mem_ready.
  assign strobe = (state_q == S_T1)
               || (state_q == S_T6 && cls == CL_LD)
               || (state_q == S_T7 && cls == CL_ST);

  assign timeout = strobe && !mem_ready && (wait_q == WAIT_LAST);

  assign done_st = run ? S_T0 : S_IDLE;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = (strobe && !mem_ready && !timeout)
            ? wait_q + CW'(1) : '0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (cls)
          CL_HALT: state_d = S_HALT;
          CL_MFHI, CL_MFLO, CL_IN,
          CL_OUT, CL_NOP: state_d = done_st;
          default: state_d = S_T4;
        endcase
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        case (cls)
          CL_MULDIV, CL_LD, CL_ST: state_d = S_T6;
          default: state_d = done_st;
        endcase
      end
      S_T6: begin
        case (cls)
          CL_LD:   if (mem_ready) state_d = S_T7;
          CL_ST:   state_d = S_T7;
          default: state_d = done_st;
        endcase
      end
      S_T7: begin
        if (cls != CL_ST || mem_ready) state_d = done_st;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // mem_ready outranks the timeout, which already excludes it.
    if (timeout) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end
  end

  always_comb begin
    bus_sel       = SEL_R0;
    reg_in        = '0;
    pc_in         = 1'b0;
    ir_in         = 1'b0;
    mar_in        = 1'b0;
    mdr_in        = 1'b0;
    y_in          = 1'b0;
    z_in          = 1'b0;
    hi_in         = 1'b0;
    lo_in         = 1'b0;
    inc_pc        = 1'b0;
    alu_op        = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mdr_src_mem   = 1'b0;
    outport_in    = 1'b0;
    busy          = 1'b0;
    halted        = 1'b0;
    mem_fault     = 1'b0;
    // clear silences everything in its own cycle so an aborted
    // instruction cannot write past the reset edge.
    pc_load_reset = clear;
    if (!clear) begin
      busy      = (state_q != S_IDLE) && (state_q != S_HALT);
      halted    = (state_q == S_HALT);
      mem_fault = fault_q;
      case (state_q)
        S_T0: begin
          bus_sel = SEL_PC;
          mar_in  = 1'b1;
          inc_pc  = 1'b1;
          z_in    = 1'b1;
        end
        S_T1: begin
          bus_sel     = SEL_ZLO;
          pc_in       = 1'b1;
          mem_read    = 1'b1;
          mdr_src_mem = 1'b1;
          mdr_in      = 1'b1;
        end
        S_T2: begin
          bus_sel = SEL_MDR;
          ir_in   = 1'b1;
        end
        S_T3: begin
          case (cls)
            CL_MFHI: begin
              bus_sel = SEL_HI;
              reg_in  = onehot16(ra);
            end
            CL_MFLO: begin
              bus_sel = SEL_LO;
              reg_in  = onehot16(ra);
            end
`ifdef INPORT_EN
            CL_IN: begin
              bus_sel = SEL_IN;
              reg_in  = onehot16(ra);
            end
            CL_OUT: begin
              bus_sel    = {1'b0, ra};
              outport_in = 1'b1;
            end
`endif
            CL_RTYPE, CL_IMM, CL_MULDIV,
            CL_LD, CL_ST: begin
              bus_sel = {1'b0, rb};
              y_in    = 1'b1;
            end
            default: ;
          endcase
        end
        S_T4: begin
          bus_sel = imm ? SEL_C : {1'b0, rc};
          alu_op  = op;
          z_in    = 1'b1;
        end
        S_T5: begin
          bus_sel = SEL_ZLO;
          case (cls)
            CL_MULDIV:    lo_in  = 1'b1;
            CL_LD, CL_ST: mar_in = 1'b1;
            default:      reg_in = onehot16(ra);
          endcase
        end
        S_T6: begin
          case (cls)
            CL_MULDIV: begin
              bus_sel = SEL_ZHI;
              hi_in   = 1'b1;
            end
            CL_LD: begin
              mem_read    = 1'b1;
              mdr_src_mem = 1'b1;
              mdr_in      = 1'b1;
            end
            CL_ST: begin
              bus_sel = {1'b0, ra};
              mdr_in  = 1'b1;
            end
            default: ;
          endcase
        end
        S_T7: begin
          if (cls == CL_LD) begin
            bus_sel = SEL_MDR;
            reg_in  = onehot16(ra);
          end else if (cls == CL_ST) begin
            mem_write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
